alu_multicycle: RTL and testbench

Parametrised multi-cycle ALU for the MIPS datapath, successor to the fixed 32-bit combinational ALU. It extends the add / subtract / XOR / set-less-than set with unsigned set-less-than, iterative unsigned multiply and iterative unsigned divide. Operands are latched on a Start/Done handshake, and results and flags are registered. It sits in the EX stage; the control unit stalls the pipeline while Busy is high.

---
 rtl/alu_multicycle.sv | 196 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU with registered results; ALU_MULDIV_EN builds iterative MULU/DIVU
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Hi,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow,
  output logic             Negative,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] op_xor  = 3'b001;
  localparam logic [2:0] op_sub  = 3'b010;
  localparam logic [2:0] op_slt  = 3'b011;
  localparam logic [2:0] op_mulu = 3'b100;
  localparam logic [2:0] op_divu = 3'b101;
  localparam logic [2:0] op_sltu = 3'b110;
  localparam logic [WIDTH:0] one_w = 1;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] sc_out;
  logic             sc_c, sc_v;

  logic             res_load;
  logic [WIDTH-1:0] res_out, res_hi;
  logic             res_c, res_v;

  // Single-cycle operations straight from the bus operands
  always_comb begin
    sc_out  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    add_sum = {1'b0, BusA} + {1'b0, BusB};
    sub_sum = {1'b0, BusA} + {1'b0, ~BusB} + one_w;
    add_v   = (BusA[WIDTH-1] ^ BusB[WIDTH-1] ^ add_sum[WIDTH-1]) ^ add_sum[WIDTH];
    sub_v   = (BusA[WIDTH-1] ^ ~BusB[WIDTH-1] ^ sub_sum[WIDTH-1]) ^ sub_sum[WIDTH];
    case (ALUControl)
      op_xor:  sc_out = BusA ^ BusB;
      op_sub: begin
        sc_out = sub_sum[WIDTH-1:0];
        sc_c   = ~sub_sum[WIDTH];
        sc_v   = sub_v;
      end
      op_slt:  sc_out = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_v};
      op_sltu: sc_out = {{(WIDTH-1){1'b0}}, ~sub_sum[WIDTH]};
      op_mulu, op_divu: sc_out = '0;
      default: begin
        sc_out = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_v   = add_v;
      end
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] last_cnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] acc, mul_acc;
  logic [WIDTH-1:0]   op_a, op_b, div_rem, div_quo;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [CW-1:0]      cnt;

  assign Busy = (state != IDLE);

  // State register; reset abandons any iteration in flight
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, iteration arithmetic and result selection
  always_comb begin
    state_next = state;
    res_load   = 1'b0;
    res_out    = sc_out;
    res_hi     = '0;
    res_c      = sc_c;
    res_v      = sc_v;
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_a[0] ? {1'b0, op_b} : '0);
    mul_acc    = {mul_sum, acc[WIDTH-1:1]};
    div_shift  = {acc[2*WIDTH-1:WIDTH], op_a[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, op_b});
    div_diff   = div_shift - {1'b0, op_b};
    div_rem    = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo    = {op_a[WIDTH-2:0], div_ge};
    case (state)
      IDLE: begin
        if (Start) begin
          if (ALUControl == op_mulu)      state_next = MUL;
          else if (ALUControl == op_divu) state_next = DIV;
          else                            res_load   = 1'b1;
        end
      end
      MUL: begin
        if (cnt == last_cnt) begin
          state_next = IDLE;
          res_load   = 1'b1;
          res_out    = mul_acc[WIDTH-1:0];
          res_hi     = mul_acc[2*WIDTH-1:WIDTH];
          res_c      = 1'b0;
          res_v      = (mul_acc[2*WIDTH-1:WIDTH] != '0);
        end
      end
      DIV: begin
        if (cnt == last_cnt) begin
          state_next = IDLE;
          res_load   = 1'b1;
          res_out    = div_quo;
          res_hi     = div_rem;
          res_c      = 1'b0;
          res_v      = (op_b == '0);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch and one multiply/divide step per cycle; a zero divisor falls out as all-ones quotient, remainder A
  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc  <= '0;
      op_a <= '0;
      op_b <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && (ALUControl == op_mulu || ALUControl == op_divu)) begin
            op_a <= BusA;
            op_b <= BusB;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        MUL: begin
          acc  <= mul_acc;
          op_a <= op_a >> 1;
          cnt  <= cnt + 1'b1;
        end
        DIV: begin
          acc[2*WIDTH-1:WIDTH] <= div_rem;
          op_a                 <= div_quo;
          cnt                  <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end
`else
  assign Busy     = 1'b0;
  assign res_load = Start;
  assign res_out  = sc_out;
  assign res_hi   = '0;
  assign res_c    = sc_c;
  assign res_v    = sc_v;
`endif

  // Result and flag registers; they hold between Done pulses
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Output   <= '0;
      Hi       <= '0;
      CarryOut <= 1'b0;
      Overflow <= 1'b0;
      Negative <= 1'b0;
      Zero     <= 1'b1;
      Done     <= 1'b0;
    end else begin
      Done <= res_load;
      if (res_load) begin
        Output   <= res_out;
        Hi       <= res_hi;
        CarryOut <= res_c;
        Overflow <= res_v;
        Zero     <= (res_out == '0);
        Negative <= res_out[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;

  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit muldiv = 1'b1;
`else
  localparam bit muldiv = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         c, z, v, n;
    int           cyc;
  } exp_t;

  logic         Clock = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic [2:0]   ALUControl = 3'd0;
  logic [W-1:0] BusA = '0, BusB = '0;
  logic [W-1:0] Output, Hi;
  logic         CarryOut, Zero, Overflow, Negative, Busy, Done;

  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   busy_lo = 1, busy_hi = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t hold, mon_e;

  alu_multicycle #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ALUControl(ALUControl),
    .BusA(BusA), .BusB(BusB), .Output(Output), .Hi(Hi), .CarryOut(CarryOut),
    .Zero(Zero), .Overflow(Overflow), .Negative(Negative), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sbv, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    e.out = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.cyc = 0;
    case (op)
      3'd1: e.out = a ^ b;
      3'd2: begin
        e.out = a - b;
        e.c   = (a < b);
        r     = sa - sbv;
        e.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd3: e.out = (sa < sbv) ? 1 : 0;
      3'd6: e.out = (a < b) ? 1 : 0;
      3'd4: if (muldiv) begin
        u     = {32'd0, a} * {32'd0, b};
        e.out = u[31:0];
        e.hi  = u[63:32];
        e.v   = (e.hi != 0);
      end
      3'd5: if (muldiv) begin
        if (b == 0) begin
          e.out = '1; e.hi = a; e.v = 1'b1;
        end else begin
          e.out = a / b; e.hi = a % b;
        end
      end
      default: begin
        u     = {32'd0, a} + {32'd0, b};
        e.out = u[31:0];
        e.c   = u[32];
        r     = sa + sbv;
        e.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
    endcase
    e.z = (e.out == 0);
    e.n = e.out[W-1];
    return e;
  endfunction

  function automatic exp_t reset_vals();
    exp_t e;
    e.out = '0; e.hi = '0; e.c = 1'b0; e.z = 1'b1; e.v = 1'b0; e.n = 1'b0; e.cyc = 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: pop the scoreboard on Done, otherwise results must hold; Busy follows the issued op
  always @(negedge Clock) begin
    if (mon_en) begin
      if (Done) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got Done=1 expected 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("output", 64'(Output), 64'(mon_e.out));
          chk("hi", 64'(Hi), 64'(mon_e.hi));
          chk("flags_czvn", 64'({CarryOut, Zero, Overflow, Negative}),
              64'({mon_e.c, mon_e.z, mon_e.v, mon_e.n}));
          hold = mon_e;
        end
      end else begin
        chk("hold_output", 64'(Output), 64'(hold.out));
        chk("hold_hi", 64'(Hi), 64'(hold.hi));
        chk("hold_flags", 64'({CarryOut, Zero, Overflow, Negative}),
            64'({hold.c, hold.z, hold.v, hold.n}));
      end
      chk("busy", 64'(Busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_output"}, 64'(Output), 64'd0);
    chk({tag, "_hi"}, 64'(Hi), 64'd0);
    chk({tag, "_flags_czvn"}, 64'({CarryOut, Zero, Overflow, Negative}), 64'b0100);
    chk({tag, "_busy_done"}, 64'({Busy, Done}), 64'b00);
  endtask

  // Issue one op; multi-cycle ops wait out their latency with stray Start pulses, returning in the Done cycle
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   d;
    e = model(op, a, b);
    d = (muldiv && (op == 3'd4 || op == 3'd5)) ? W : 0;
    e.cyc = cyc + 1 + d;
    sb.push_back(e);
    if (d > 0) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + d;
    end
    Start = 1'b1; ALUControl = op; BusA = a; BusB = b;
    @(posedge Clock); #1;
    Start = 1'b0; ALUControl = 3'($urandom_range(0, 7)); BusA = W'($urandom); BusB = W'($urandom);
    for (int i = 0; i < d; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        Start = 1'b1; ALUControl = 3'($urandom_range(0, 7));
        BusA = W'($urandom); BusB = W'($urandom);
      end
      @(posedge Clock); #1;
      Start = 1'b0;
    end
  endtask

  // MULU interrupted by reset on its tenth cycle: no Done, everything back to reset values
  task automatic reset_mid_mul();
    exp_t e;
    e = model(3'd4, 32'h1234_5678, 32'h9ABC_DEF0);
    e.cyc = cyc + 1;
    if (muldiv) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + W;
    end
    sb.push_back(e);
    Start = 1'b1; ALUControl = 3'd4; BusA = 32'h1234_5678; BusB = 32'h9ABC_DEF0;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (8) begin
      @(posedge Clock); #1;
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    if (muldiv) sb.delete();
    busy_lo = 1; busy_hi = 0;
    hold = reset_vals();
    check_reset_state("mid_reset");
  endtask

  initial begin
    hold = reset_vals();
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    check_reset_state("reset");
    mon_en = 1'b1;

    issue(3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(3'd2, 32'd5, 32'd5);
    issue(3'd3, 32'hFFFF_FFFF, 32'd1);
    issue(3'd6, 32'hFFFF_FFFF, 32'd1);
    issue(3'd0, 32'hFFFF_FFFF, 32'd1);
    issue(3'd2, 32'h8000_0000, 32'd1);
    issue(3'd1, 32'hA5A5_0F0F, 32'h5A5A_0F0F);
    issue(3'd7, 32'd40, 32'd2);
    issue(3'd4, 32'hFFFF_FFFF, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd5, 32'd9, 32'd0);
    issue(3'd0, 32'd3, 32'd4);
    reset_mid_mul();
    issue(3'd5, 32'hFFFF_FFFF, 32'd16);
    issue(3'd4, 32'd3, 32'd4);

    for (int i = 0; i < 200; i++)
      issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());

    for (int i = 0; i < 3 * W && sb.size() != 0; i++) begin
      @(posedge Clock); #1;
    end
    @(negedge Clock); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
